// File: rtl/mixcol_sched_if.sv
// Handshake and column-unit bus for mixcol_sched: state in, column out/in, result out.
interface mixcol_sched_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         col_valid;
    logic [31:0]  col_out;
    logic [31:0]  col_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport slave (
        input  in_valid, in_data, in_bypass, col_in, out_ready,
        output in_ready, col_valid, col_out, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, in_bypass, col_in, out_ready,
        input  in_ready, col_valid, col_out, out_valid, out_data
    );
endinterface

// File: rtl/mixcol_sched.sv
// Column-serial AES MixColumns scheduler around a shared fixed-latency column unit.
// Optional MIXCOL_SCHED_PERF_EN adds blk_count, a count of completed non-bypass blocks.
module mixcol_sched #(
    parameter int COL_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mixcol_sched_if.slave   bus
`ifdef MIXCOL_SCHED_PERF_EN
    ,
    output logic [15:0]     blk_count
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                     state, state_nxt;
    logic [1:0]                 idx_q;
    logic                       byp_q;
    // Column 0 lives in the top word, so column k is word index ~k.
    logic [3:0][31:0]           lat_q;
    logic [3:0][31:0]           res_q;
    logic [COL_LAT-1:0]         tag_vld_pipe;
    logic [COL_LAT-1:0][1:0]    tag_idx_pipe;

    logic                       in_ready, col_valid, out_valid;
    logic [31:0]                col_out;
    logic                       accept, cap;
    logic [1:0]                 cap_idx;

    assign accept  = bus.in_valid & in_ready;
    assign cap     = tag_vld_pipe[COL_LAT-1];
    assign cap_idx = tag_idx_pipe[COL_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = bus.in_bypass ? DONE : ISSUE;
            ISSUE:   if (idx_q == 2'd3) state_nxt = DRAIN;
            DRAIN:   if (cap && cap_idx == 2'd3) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        col_valid = 1'b0;
        col_out   = '0;
        out_valid = 1'b0;
        case (state)
            IDLE:  in_ready = 1'b1;
            ISSUE: begin
                col_valid = 1'b1;
                col_out   = lat_q[~idx_q];
            end
            DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Capture follows the tag pipe alone, so it keeps working across FSM states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            byp_q        <= 1'b0;
            lat_q        <= '0;
            res_q        <= '0;
            tag_vld_pipe <= '0;
            tag_idx_pipe <= '0;
        end else begin
            tag_vld_pipe[0] <= col_valid;
            tag_idx_pipe[0] <= idx_q;
            for (int i = 1; i < COL_LAT; i++) begin
                tag_vld_pipe[i] <= tag_vld_pipe[i-1];
                tag_idx_pipe[i] <= tag_idx_pipe[i-1];
            end
            if (col_valid) idx_q <= idx_q + 2'd1;
            if (cap) res_q[~cap_idx] <= bus.col_in;
            if (accept) begin
                lat_q <= bus.in_data;
                byp_q <= bus.in_bypass;
                idx_q <= '0;
                if (bus.in_bypass) res_q <= bus.in_data;
            end
        end
    end

`ifdef MIXCOL_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blk_count <= '0;
        else if (out_valid && bus.out_ready && !byp_q)
            blk_count <= blk_count + 16'd1;
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.col_valid = col_valid;
    assign bus.col_out   = col_out;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = res_q;

endmodule

// File: tb/tb_mixcol_sched.sv
// Directed bench for mixcol_sched: two instances (COL_LAT 1 and 3) with behavioural column units.
module tb_mixcol_sched;

    logic clk, rst_n;
    int   n_chk, n_fail;
    int   cv_cnt;

    mixcol_sched_if b1 ();
    mixcol_sched_if b3 ();

`ifdef MIXCOL_SCHED_PERF_EN
    logic [15:0] cnt1, cnt3;
    mixcol_sched #(.COL_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1), .blk_count(cnt1));
    mixcol_sched #(.COL_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3), .blk_count(cnt3));
`else
    mixcol_sched #(.COL_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mixcol_sched #(.COL_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixc(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Registered column units, one and three cycles deep.
    logic [31:0] p1;
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        p1    <= b1.col_valid ? mixc(b1.col_out) : 32'h0;
        p3[0] <= b3.col_valid ? mixc(b3.col_out) : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.col_in = p1;
    assign b3.col_in = p3[2];

    always @(negedge clk) if (b1.col_valid) cv_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ack1();
        b1.out_ready = 1'b1;
        tick();
        b1.out_ready = 1'b0;
    endtask

    // Accept one block on the COL_LAT=1 instance and run to out_valid (bounded).
    task automatic run_blk(input logic [127:0] d, input logic byp, output int edges,
                           output int ncol, output logic [31:0] cols [4], output int cyc [4]);
        b1.in_data   = d;
        b1.in_bypass = byp;
        b1.in_valid  = 1'b1;
        tick();
        b1.in_valid  = 1'b0;
        edges = 0;
        ncol  = 0;
        for (int i = 0; i < 4; i++) begin cols[i] = '0; cyc[i] = -1; end
        while (!b1.out_valid && edges < 30) begin
            if (b1.col_valid) begin
                if (ncol < 4) begin cols[ncol] = b1.col_out; cyc[ncol] = edges; end
                ncol++;
            end
            tick();
            edges++;
        end
    endtask

    localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] RES_A = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] VEC_B = 128'hd4bf5d30_00000000_00000000_00000000;
    localparam logic [127:0] RES_B = 128'h046681e5_00000000_00000000_00000000;

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_chk++;
        if (b1.in_ready !== 1'b1 || b1.col_valid !== 1'b0 || b1.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b col_valid=%b out_valid=%b, want 1 0 0",
                     b1.in_ready, b1.col_valid, b1.out_valid);
        end
        n_chk++;
        if (b1.col_out !== 32'h0 || b1.out_data !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: col_out=%h out_data=%h, want 0", b1.col_out, b1.out_data);
        end
        n_chk++;
        if (b3.in_ready !== 1'b1 || b3.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_lat3: in_ready=%b out_valid=%b, want 1 0", b3.in_ready, b3.out_valid);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (b1.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b want 1", b1.in_ready);
        end
    endtask

    task automatic test_mix();
        int e, n, c0;
        logic [31:0] cols [4];
        int cyc [4];
        logic [31:0] exp_c [4];
        exp_c = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
        c0 = cv_cnt;
        run_blk(VEC_A, 1'b0, e, n, cols, cyc);
        n_chk++;
        if (e !== 5) begin
            n_fail++;
            $display("FAIL mix_latency: %0d edges after accept, want 5", e);
        end
        n_chk++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL mix_ncol: %0d issue cycles, want 4", n);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (cols[i] !== exp_c[i] || cyc[i] !== i) begin
                n_fail++;
                $display("FAIL mix_col%0d: got %h at cycle %0d, want %h at cycle %0d",
                         i, cols[i], cyc[i], exp_c[i], i);
            end
        end
        n_chk++;
        if (b1.out_data !== RES_A) begin
            n_fail++;
            $display("FAIL mix_data: got %h want %h", b1.out_data, RES_A);
        end
        ack1();
        n_chk++;
        if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mix_handshake: in_ready=%b out_valid=%b, want 1 0", b1.in_ready, b1.out_valid);
        end
        n_chk++;
        if (cv_cnt - c0 !== 4) begin
            n_fail++;
            $display("FAIL mix_cv_total: %0d col_valid cycles, want 4", cv_cnt - c0);
        end
    endtask

    // out_valid must already be high right after the accept edge (one edge in total).
    task automatic test_bypass();
        int e, n, c0;
        logic [31:0] cols [4];
        int cyc [4];
        c0 = cv_cnt;
        run_blk(VEC_A, 1'b1, e, n, cols, cyc);
        n_chk++;
        if (e !== 0) begin
            n_fail++;
            $display("FAIL byp_latency: %0d extra edges after accept, want 0", e);
        end
        n_chk++;
        if (b1.out_data !== VEC_A) begin
            n_fail++;
            $display("FAIL byp_data: got %h want %h", b1.out_data, VEC_A);
        end
        ack1();
        tick();
        n_chk++;
        if (cv_cnt - c0 !== 0) begin
            n_fail++;
            $display("FAIL byp_col_valid: %0d col_valid cycles, want 0", cv_cnt - c0);
        end
    endtask

    task automatic test_lat3();
        int e, n;
        b3.in_data   = VEC_B;
        b3.in_bypass = 1'b0;
        b3.in_valid  = 1'b1;
        tick();
        b3.in_valid  = 1'b0;
        e = 0;
        n = 0;
        while (!b3.out_valid && e < 30) begin
            if (b3.col_valid) n++;
            tick();
            e++;
        end
        n_chk++;
        if (e !== 7) begin
            n_fail++;
            $display("FAIL lat3_latency: %0d edges after accept, want 7", e);
        end
        n_chk++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL lat3_ncol: %0d issue cycles, want 4", n);
        end
        n_chk++;
        if (b3.out_data !== RES_B) begin
            n_fail++;
            $display("FAIL lat3_data: got %h want %h", b3.out_data, RES_B);
        end
        b3.out_ready = 1'b1;
        tick();
        b3.out_ready = 1'b0;
        n_chk++;
        if (b3.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lat3_handshake: in_ready=%b want 1", b3.in_ready);
        end
    endtask

    task automatic test_backpressure();
        int e, n, bad;
        logic [31:0] cols [4];
        int cyc [4];
        run_blk(VEC_B, 1'b0, e, n, cols, cyc);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            b1.in_valid  = 1'b1;
            b1.in_data   = VEC_A;
            b1.in_bypass = 1'b1;
            tick();
            if (b1.out_data !== RES_B || b1.in_ready !== 1'b0 || b1.out_valid !== 1'b1) bad++;
        end
        b1.in_valid = 1'b0;
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold: %0d cycles lost stability (data=%h in_ready=%b), want 0",
                     bad, b1.out_data, b1.in_ready);
        end
        ack1();
        n_chk++;
        if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b, want 1 0", b1.in_ready, b1.out_valid);
        end
        run_blk(VEC_A, 1'b0, e, n, cols, cyc);
        n_chk++;
        if (b1.out_data !== RES_A || e !== 5) begin
            n_fail++;
            $display("FAIL hold_second: data=%h edges=%0d, want %h 5", b1.out_data, e, RES_A);
        end
        ack1();
    endtask

    task automatic test_midreset();
        int e, n;
        logic [31:0] cols [4];
        int cyc [4];
        b1.in_data   = VEC_A;
        b1.in_bypass = 1'b0;
        b1.in_valid  = 1'b1;
        tick();
        b1.in_valid  = 1'b0;
        tick();
        tick();
        n_chk++;
        if (b1.col_valid !== 1'b1 || b1.col_out !== 32'h01010101) begin
            n_fail++;
            $display("FAIL mid_index2: col_valid=%b col_out=%h, want 1 01010101", b1.col_valid, b1.col_out);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (b1.in_ready !== 1'b1 || b1.col_valid !== 1'b0 || b1.col_out !== 32'h0 ||
            b1.out_valid !== 1'b0 || b1.out_data !== 128'h0) begin
            n_fail++;
            $display("FAIL mid_reset: in_ready=%b col_valid=%b col_out=%h out_valid=%b out_data=%h, want reset values",
                     b1.in_ready, b1.col_valid, b1.col_out, b1.out_valid, b1.out_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_blk(VEC_B, 1'b0, e, n, cols, cyc);
        n_chk++;
        if (b1.out_data !== RES_B || e !== 5 || n !== 4) begin
            n_fail++;
            $display("FAIL mid_next: data=%h edges=%0d ncol=%0d, want %h 5 4", b1.out_data, e, n, RES_B);
        end
        ack1();
    endtask

`ifdef MIXCOL_SCHED_PERF_EN
    task automatic test_perf();
        int e, n;
        logic [31:0] cols [4];
        int cyc [4];
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (cnt1 !== 16'd0) begin
            n_fail++;
            $display("FAIL perf_reset: blk_count=%0d want 0", cnt1);
        end
        for (int i = 0; i < 4; i++) begin
            run_blk(VEC_A, (i == 2), e, n, cols, cyc);
            ack1();
        end
        n_chk++;
        if (cnt1 !== 16'd3) begin
            n_fail++;
            $display("FAIL perf_count: blk_count=%0d want 3", cnt1);
        end
        force dut1.blk_count = 16'hfffe;
        #1;
        release dut1.blk_count;
        run_blk(VEC_B, 1'b0, e, n, cols, cyc);
        ack1();
        n_chk++;
        if (cnt1 !== 16'hffff) begin
            n_fail++;
            $display("FAIL perf_pre_wrap: blk_count=%h want ffff", cnt1);
        end
        run_blk(VEC_B, 1'b0, e, n, cols, cyc);
        ack1();
        n_chk++;
        if (cnt1 !== 16'h0000) begin
            n_fail++;
            $display("FAIL perf_wrap: blk_count=%h want 0000", cnt1);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cv_cnt = 0;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_bypass = 1'b0; b1.out_ready = 1'b0;
        b3.in_valid = 1'b0; b3.in_data = '0; b3.in_bypass = 1'b0; b3.out_ready = 1'b0;
        test_reset();
        test_mix();
        test_bypass();
        test_lat3();
        test_backpressure();
        test_midreset();
`ifdef MIXCOL_SCHED_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mixcol_sched.md
Name: mixcol_sched

Overview:
- Column-serial scheduler for the AES MixColumns stage.
- Accepts a 128-bit state over a valid/ready handshake and issues its four 32-bit columns, one per cycle, to a single shared external column unit (the 4-byte GF(2^8) matrix multiplier).
- The column unit has fixed registered latency. The scheduler collects the returned columns, reassembles the 128-bit result and presents it over a valid/ready output handshake.
- Also supports a per-block bypass for the AES final round, which has no MixColumns.

Parameters:
- COL_LAT, 1: latency of the external column unit in cycles, from col_valid high to matching col_in; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  scheduler can accept a state.
- in_data  in  128  input state; column 0 = bits [127:96], column 3 = bits [31:0].
- in_bypass  in  1  sampled with in_data; 1 = pass the state through unmodified.
- col_valid  out  1  a column is being issued this cycle.
- col_out  out  32  column to the column unit; byte 0 (row 0) in bits [31:24].
- col_in  in  32  result column from the column unit, valid COL_LAT cycles after its col_valid.
- out_valid  out  1  result state valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  128  result state, same column ordering as in_data.

Behaviour:
- Reset values (asynchronous assertion):
  - state = IDLE, in_ready = 1.
  - col_valid = 0, col_out = 0, out_valid = 0, out_data = 0.
  - Issue index = 0; capture pipeline tags cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch in_data and in_bypass.
  - Bypass = 1: go to DONE; out_data = latched state.
  - Bypass = 0: go to ISSUE with index = 0.
- ISSUE:
  - in_ready = 0, col_valid = 1, col_out = latched column[index].
  - index increments each cycle; after index 3, go to DRAIN.
  - Exactly 4 issue cycles, back to back, with no gaps.
- Capture:
  - Each issue pushes a valid tag plus its 2-bit index into a COL_LAT-deep shift pipeline.
  - When a tag emerges, col_in is written into result column[tag index].
  - Capture is independent of the FSM state.
- DRAIN:
  - col_valid = 0; wait for the tag of column 3 to emerge.
  - On the edge that captures column 3, go to DONE.
- DONE:
  - out_valid = 1; out_data is stable and holds while out_ready = 0.
  - On out_valid & out_ready, go to IDLE.
  - in_ready returns to 1 on the following cycle; there is no same-cycle accept in DONE.
- Latency, counted in rising edges from the accept edge to out_valid high:
  - MixColumns path: COL_LAT + 4 (5 at default).
  - Bypass path: 1.
- Throughput: one block per COL_LAT + 6 cycles, assuming out_ready is held high.
- The column unit has no backpressure. col_valid is never asserted outside ISSUE.
- rst_n asserted mid-operation: immediate return to reset values; in-flight tags and any partial result are discarded.
- in_data and in_bypass are don't-care while in_ready = 0.

Optional Feature:
- Macro: MIXCOL_SCHED_PERF_EN.
- Defined:
  - Adds output port blk_count [15:0], reset to 0.
  - Increments on each out_valid & out_ready handshake where the block was not bypassed.
  - Wraps from 16'hFFFF to 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Bench setup: behavioural column unit with COL_LAT = 1. Drive in_data = db135345_f20a225c_01010101_c6c6c6c6 with bypass = 0 -> out_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6; out_valid rises 5 edges after accept; col_valid high exactly 4 consecutive cycles carrying db135345, f20a225c, 01010101, c6c6c6c6 in that order.
- Same vector with bypass = 1 -> out_data equals in_data 1 edge after accept; col_valid never asserts.
- COL_LAT = 3, in_data column 0 = d4bf5d30, others 00000000 -> out_data = 046681e5_00000000_00000000_00000000; out_valid rises 7 edges after accept.
- Hold out_ready = 0 for 10 cycles in DONE -> out_data stable, in_ready = 0, in_valid ignored; release -> in_ready = 1 on the next cycle; a second block is accepted and processed correctly.
- Assert rst_n = 0 in ISSUE with index = 2 -> outputs return to reset values immediately; next block after release produces the correct result with no stale columns.
- With MIXCOL_SCHED_PERF_EN: 3 MixColumns blocks plus 1 bypass block -> blk_count = 3; preload the counter near wrap and drive 2 blocks to check the 16'hFFFF -> 0 wrap.
